// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: streams one VRAM write per cycle, row-major.
// Optional VRAM_FILL_CLIP_EN drops writes that fall outside the framebuffer.
module vram_rect_fill #(
  parameter int FB_W = 200,
  parameter int FB_H = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_x_i,
  input  logic [7:0]  cmd_y_i,
  input  logic [7:0]  cmd_w_i,
  input  logic [7:0]  cmd_h_i,
  input  logic [7:0]  cmd_color_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        v_we_o,
  output logic [14:0] v_addr_o,
  output logic [7:0]  v_data_o
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state;
  logic [7:0]  x_r, w_r, h_r, color_r;
  logic [7:0]  col, row;
  logic [8:0]  px, py;
  logic [23:0] base;

  logic        accept, end_col, end_row, last, inb;
  logic [7:0]  n_col, n_row;
  logic [8:0]  n_px, n_py;
  logic [23:0] n_base, lin;

  // n_* describe the pixel presented on the next cycle
  always_comb begin
    accept  = (state == IDLE) && cmd_valid_i && !abort_i;
    end_col = ({1'b0, col} + 9'd1) == {1'b0, w_r};
    end_row = ({1'b0, row} + 9'd1) == {1'b0, h_r};
    last    = end_col && end_row;
    n_col   = col + 8'd1;
    n_row   = row;
    n_px    = px + 9'd1;
    n_py    = py;
    n_base  = base;
    if (state == IDLE) begin
      n_col  = '0;
      n_row  = '0;
      n_px   = {1'b0, cmd_x_i};
      n_py   = {1'b0, cmd_y_i};
      n_base = 24'(cmd_y_i) * 24'(FB_W);
    end else if (end_col) begin
      n_col  = '0;
      n_row  = row + 8'd1;
      n_px   = {1'b0, x_r};
      n_py   = py + 9'd1;
      n_base = base + 24'(FB_W);
    end
    lin = n_base + 24'(n_px);
`ifdef VRAM_FILL_CLIP_EN
    inb = (32'(n_px) < 32'(FB_W)) && (32'(n_py) < 32'(FB_H));
`else
    inb = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      v_we_o      <= 1'b0;
      v_addr_o    <= '0;
      v_data_o    <= '0;
      x_r         <= '0;
      w_r         <= '0;
      h_r         <= '0;
      color_r     <= '0;
      col         <= '0;
      row         <= '0;
      px          <= '0;
      py          <= '0;
      base        <= '0;
    end else begin
      done_o   <= 1'b0;
      v_we_o   <= 1'b0;
      v_addr_o <= '0;
      v_data_o <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            x_r     <= cmd_x_i;
            w_r     <= cmd_w_i;
            h_r     <= cmd_h_i;
            color_r <= cmd_color_i;
            col     <= n_col;
            row     <= n_row;
            px      <= n_px;
            py      <= n_py;
            base    <= n_base;
            if (cmd_w_i == 8'd0 || cmd_h_i == 8'd0) begin
              done_o <= 1'b1;
            end else begin
              state       <= FILL;
              cmd_ready_o <= 1'b0;
              busy_o      <= 1'b1;
              v_we_o      <= inb;
              v_addr_o    <= inb ? lin[14:0] : 15'd0;
              v_data_o    <= inb ? cmd_color_i : 8'd0;
            end
          end
        end
        FILL: begin
          if (abort_i || last) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= !abort_i;
          end else begin
            col      <= n_col;
            row      <= n_row;
            px       <= n_px;
            py       <= n_py;
            base     <= n_base;
            v_we_o   <= inb;
            v_addr_o <= inb ? lin[14:0] : 15'd0;
            v_data_o <= inb ? color_r : 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Scoreboard bench for vram_rect_fill: random and directed rectangles.
// Expected writes/done cycles come from a plain row-major pixel model.
module tb_vram_rect_fill;

  localparam int FB_W = 200;
  localparam int FB_H = 150;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_x_i = '0, cmd_y_i = '0, cmd_w_i = '0, cmd_h_i = '0;
  logic [7:0]  cmd_color_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, v_we_o;
  logic [14:0] v_addr_o;
  logic [7:0]  v_data_o;

  vram_rect_fill #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i),
    .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
    .cmd_color_i(cmd_color_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o),
    .v_we_o(v_we_o), .v_addr_o(v_addr_o), .v_data_o(v_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Pixel (col,row) of a rectangle accepted on edge a appears on cycle a+k
  function automatic void model(int x, int y, int w, int h, int c,
                                int a, int abort_at);
    int n;
    n = w * h;
    if (n == 0) begin
      dq.push_back(a);
      return;
    end
    for (int k = 0; k < n; k++) begin
      int px, py;
      bit keep;
      if (abort_at >= 0 && k > abort_at) break;
      px = x + (k % w);
      py = y + (k / w);
      keep = 1'b1;
`ifdef VRAM_FILL_CLIP_EN
      keep = (px < FB_W) && (py < FB_H);
`endif
      if (keep) wq.push_back('{a + k, (py * FB_W + px) % 32768, c});
    end
    if (abort_at < 0) dq.push_back(a + n);
  endfunction

  always @(negedge clk) begin
    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      chk("write_missing_cycle", cyc, wq[0].cyc);
      void'(wq.pop_front());
    end
    while (dq.size() > 0 && dq[0] < cyc) begin
      chk("done_missing_cycle", cyc, dq[0]);
      void'(dq.pop_front());
    end
    if (v_we_o) begin
      if (wq.size() == 0) begin
        chk("write_unexpected_addr", v_addr_o, -1);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_addr", v_addr_o, e.addr);
        chk("write_data", v_data_o, e.data);
      end
    end else begin
      chk("idle_addr", v_addr_o, 0);
      chk("idle_data", v_data_o, 0);
    end
    if (done_o) begin
      if (dq.size() == 0) begin
        chk("done_unexpected", cyc, -1);
      end else begin
        chk("done_cycle", cyc, dq.pop_front());
      end
    end
    chk("busy_vs_ready", busy_o, !cmd_ready_o);
  end

  task automatic issue(input int x, input int y, input int w, input int h,
                       input int c, input bit junk, input int abort_at,
                       output int a);
    int t;
    t = 0;
    a = -1;
    @(negedge clk);
    while (!cmd_ready_o) begin
      if (junk) begin
        cmd_valid_i = 1'b1;
        cmd_x_i = 8'($urandom);
        cmd_y_i = 8'($urandom);
        cmd_w_i = 8'($urandom);
        cmd_h_i = 8'($urandom);
        cmd_color_i = 8'($urandom);
      end else begin
        cmd_valid_i = 1'b0;
      end
      t++;
      if (t > 3000) begin
        chk("issue_ready_timeout", t, 0);
        cmd_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid_i = 1'b1;
    cmd_x_i = 8'(x);
    cmd_y_i = 8'(y);
    cmd_w_i = 8'(w);
    cmd_h_i = 8'(h);
    cmd_color_i = 8'(c);
    a = cyc + 1;
    model(x, y, w, h, c, a, abort_at);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    while (!cmd_ready_o && t < 3000) begin
      t++;
      @(negedge clk);
    end
    chk("wait_idle_ready", cmd_ready_o, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    bit junk;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", v_we_o, 0);
    chk("rst_addr", v_addr_o, 0);
    chk("rst_data", v_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready_o, 1);
    chk("post_rst_busy", busy_o, 0);

    // expects 403,404,603,604 on cycles a..a+3, done on a+4
    issue(3, 2, 2, 2, 8'hA5, 1'b0, -1, a);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("basic_busy", busy_o, 1);
    chk("basic_first_addr", v_addr_o, 403);
    wait_idle();

    issue(10, 10, 0, 5, 8'h3C, 1'b0, -1, a);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("zero_busy", busy_o, 0);
    chk("zero_done", done_o, 1);
    chk("zero_we", v_we_o, 0);
    wait_idle();

    issue(198, 0, 4, 1, 8'h77, 1'b0, -1, a);
    wait_idle();

    issue(0, 0, 10, 1, 8'h5A, 1'b0, 1, a);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    @(negedge clk);
    chk("abort_we", v_we_o, 0);
    chk("abort_ready", cmd_ready_o, 1);
    chk("abort_busy", busy_o, 0);
    repeat (12) @(negedge clk);

    cmd_valid_i = 1'b1;
    abort_i = 1'b1;
    cmd_w_i = 8'd3;
    cmd_h_i = 8'd3;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk);
    chk("idle_abort_ready", cmd_ready_o, 1);
    chk("idle_abort_busy", busy_o, 0);
    chk("idle_abort_we", v_we_o, 0);
    chk("idle_abort_done", done_o, 0);

    for (int i = 0; i < 40; i++) begin
      int w, h;
      junk = 1'($urandom);
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      if (i % 10 == 9) begin
        w = $urandom_range(20, 60);
        h = 1;
      end
      issue($urandom_range(0, 255), $urandom_range(0, 255), w, h,
            $urandom_range(0, 255), junk, -1, a);
    end
    wait_idle();

    issue(5, 5, 4, 4, 8'hC3, 1'b0, 2, a);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midfill_rst_we", v_we_o, 0);
    chk("midfill_rst_busy", busy_o, 0);
    wq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midfill_ready", cmd_ready_o, 1);
    repeat (20) @(negedge clk);

    chk("final_writes_left", wq.size(), 0);
    chk("final_dones_left", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
